mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register, sampled only in DECODE.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag, used only in BEQEX.
REQ-005 SHALL have ports iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, outputs, 1 bit each: datapath mux and write enables.
REQ-006 SHALL have ports alu_src_b, pc_src, ALUOp, outputs, 2 bits each; ALUOp feeds alu_control (00 add, 01 sub, 10 use funct).
REQ-007 SHALL have port pc_en, output, 1 bit: PC load enable.
REQ-008 SHALL have port state, output, 4 bits: current FSM state, for debug.
REQ-009 SHALL have port illegal_op, output, 1 bit: sticky flag, set when an unsupported opcode is decoded.
REQ-010 SHALL have port instr_count, output, 16 bits: count of retired instructions.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-012 SHALL advance FETCH->DECODE unconditionally.
REQ-013 SHALL branch from DECODE by opcode: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, any other->FETCH.
REQ-014 SHALL route MEMADR->MEMRD for lw and MEMADR->MEMWR for sw, using the opcode latched in DECODE.
REQ-015 SHALL use transitions MEMRD->MEMWB, RTYPEEX->RTYPEWB, ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX each ->FETCH.
REQ-016 SHALL treat unused state codes 12-15 as a transition to FETCH on the next edge, with all outputs 0.
REQ-017 SHALL drive only the outputs listed per state below; every unlisted output SHALL be 0.
REQ-018 SHALL drive in FETCH: ir_write=1, alu_src_b=01, pc_write=1 (iord, alu_src_a, ALUOp, pc_src = 0).
REQ-019 SHALL drive in DECODE: alu_src_b=11 (ALUOp=00).
REQ-020 SHALL drive in MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10 (ALUOp=00).
REQ-021 SHALL drive in MEMRD: iord=1; in MEMWR: iord=1, mem_write=1.
REQ-022 SHALL drive in MEMWB: mem_to_reg=1, reg_write=1 (reg_dst=0); in ADDIWB: reg_write=1 (reg_dst=0, mem_to_reg=0); in RTYPEWB: reg_dst=1, reg_write=1.
REQ-023 SHALL drive in RTYPEEX: alu_src_a=1, ALUOp=10; in BEQEX: alu_src_a=1, ALUOp=01, pc_src=01, branch=1; in JEX: pc_src=10, pc_write=1.
REQ-024 SHALL compute pc_en = pc_write OR (branch AND zero), where pc_write and branch are internal per-state terms; this is the only combinational path from an input (zero) to an output.
REQ-025 SHALL give these cycles per instruction, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-026 SHALL increment instr_count by 1 on the clock edge that leaves MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX, wrapping FFFF->0000; illegal opcodes SHALL NOT count.
REQ-027 SHALL set illegal_op on the edge leaving DECODE with an unsupported opcode; only reset SHALL clear it.

Reset
REQ-028 SHALL, on rst_n=0, force state=FETCH, instr_count=0 and illegal_op=0 immediately, independent of clk.
REQ-029 SHALL, when reset is asserted mid-instruction, abandon the instruction without counting it; the first edge after release SHALL move FETCH->DECODE.
REQ-030 SHALL present the FETCH outputs (including pc_en=1) while in reset.

Structure
REQ-031 SHALL place state encodings, opcode constants and ALUOp encodings in shared header mips_defs, which alu_control also uses.
REQ-032 SHALL split the state-to-control decode into a combinational sub-module mips_mc_outdec; the state register, next-state logic and counter SHALL remain in mips_mc_control.

Verification
REQ-033 SHALL test lw: opcode=100011 after reset -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
REQ-034 SHALL test R-type then sw: opcode=000000 -> ALUOp=10 in state 6, reg_dst=1 in state 7; opcode=101011 -> mem_write=1 for exactly one cycle in state 5; instr_count=2.
REQ-035 SHALL test beq: opcode=000100 with zero=1 -> pc_en=1 and pc_src=01 in state 8; with zero=0 -> pc_en=0 in state 8.
REQ-036 SHALL test j and addi: opcode=000010 -> 3 cycles with pc_src=10 in state 11; opcode=001000 -> states 9,10 with alu_src_b=10 then reg_write=1.
REQ-037 SHALL test errors and reset: opcode=111111 -> DECODE->FETCH, illegal_op=1, count unchanged; rst_n low during state 3 -> state=0, illegal_op=0, instr_count=0 without a clock edge.
REQ-038 SHALL test wrap: preload 65535 retirements (or force the counter to FFFF), retire one instruction -> instr_count=0000.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALUOp codes and the decoded per-state control word.
package mips_defs;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJEx     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] AluBReg    = 2'b00;
  localparam logic [1:0] AluBFour   = 2'b01;
  localparam logic [1:0] AluBImm    = 2'b10;
  localparam logic [1:0] AluBImmSh  = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] aluop;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  // States whose exit retires an instruction.
  function automatic logic is_retire(input logic [3:0] st);
    return (st == StMemWb) || (st == StMemWr) || (st == StRtypeWb) ||
           (st == StBeqEx) || (st == StAddiWb) || (st == StJEx);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control decode for the multicycle MIPS FSM.
module mips_mc_outdec
  import mips_defs::*;
(
  input  logic [3:0] state,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] aluop,
  output logic       pc_write,
  output logic       branch
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      StFetch: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = AluBFour;
        c.pc_write  = 1'b1;
      end
      StDecode: c.alu_src_b = AluBImmSh;
      StMemAdr, StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = AluBImm;
      end
      StMemRd: c.iord = 1'b1;
      StMemWr: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      StAddiWb: c.reg_write = 1'b1;
      StRtypeWb: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      StRtypeEx: begin
        c.alu_src_a = 1'b1;
        c.aluop     = AluOpFunct;
      end
      StBeqEx: begin
        c.alu_src_a = 1'b1;
        c.aluop     = AluOpSub;
        c.pc_src    = PcSrcAluOut;
        c.branch    = 1'b1;
      end
      StJEx: begin
        c.pc_src   = PcSrcJump;
        c.pc_write = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign iord       = c.iord;
  assign ir_write   = c.ir_write;
  assign mem_write  = c.mem_write;
  assign reg_write  = c.reg_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign pc_src     = c.pc_src;
  assign aluop      = c.aluop;
  assign pc_write   = c.pc_write;
  assign branch     = c.branch;

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: state register, next-state logic, retired
// instruction counter and sticky illegal-opcode flag.
module mips_mc_control
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        iord,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  ALUOp,
  output logic        pc_en,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [15:0] instr_count
);

  state_e      state_q, state_d;
  logic [5:0]  op_q;
  logic [15:0] count_q;
  logic        illegal_q;
  logic        pc_write;
  logic        branch;
  logic        dec_illegal;

  always_comb begin
    state_d     = StFetch;
    dec_illegal = 1'b0;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (opcode == OpLw || opcode == OpSw) state_d = StMemAdr;
        else if (opcode == OpRtype)           state_d = StRtypeEx;
        else if (opcode == OpBeq)             state_d = StBeqEx;
        else if (opcode == OpAddi)            state_d = StAddiEx;
        else if (opcode == OpJ)               state_d = StJEx;
        else begin
          state_d     = StFetch;
          dec_illegal = 1'b1;
        end
      end
      // lw/sw split uses the opcode captured in DECODE, not the live input.
      StMemAdr:  state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode;
      if (is_retire(state_q)) count_q <= count_q + 16'd1;
      if (dec_illegal) illegal_q <= 1'b1;
    end
  end

  mips_mc_outdec u_outdec (
    .state      (state_q),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .aluop      (ALUOp),
    .pc_write   (pc_write),
    .branch     (branch)
  );

  assign pc_en       = pc_write | (branch & zero);
  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomised self-checking bench for mips_mc_control against an
// instruction-level reference model (state trace per opcode class).
module tb_mips_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src, ALUOp;
  logic        pc_en;
  logic [3:0]  state;
  logic        illegal_op;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_count;
  logic        m_illegal;

  mips_mc_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .iord        (iord),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .ALUOp       (ALUOp),
    .pc_en       (pc_en),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // {iord,ir_write,mem_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,pc_src,ALUOp,pc_en}
  logic [13:0] act;
  assign act = {iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, ALUOp, pc_en};

  function automatic logic [13:0] exp_ctrl(input int st, input logic z);
    logic [13:0] e;
    e = '0;
    case (st)
      0:  begin e[12] = 1; e[6:5] = 2'b01; e[0] = 1; end
      1:  e[6:5] = 2'b11;
      2, 9: begin e[7] = 1; e[6:5] = 2'b10; end
      3:  e[13] = 1;
      5:  begin e[13] = 1; e[11] = 1; end
      4:  begin e[8] = 1; e[10] = 1; end
      10: e[10] = 1;
      7:  begin e[9] = 1; e[10] = 1; end
      6:  begin e[7] = 1; e[2:1] = 2'b10; end
      8:  begin e[7] = 1; e[2:1] = 2'b01; e[4:3] = 2'b01; e[0] = z; end
      11: begin e[4:3] = 2'b10; e[0] = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Expected state trace of one instruction, FETCH included.
  function automatic void trace(input logic [5:0] op, output int seq[$], output logic legal);
    seq = {0, 1};
    legal = 1'b1;
    case (op)
      6'b100011: seq = {0, 1, 2, 3, 4};
      6'b101011: seq = {0, 1, 2, 5};
      6'b000000: seq = {0, 1, 6, 7};
      6'b001000: seq = {0, 1, 9, 10};
      6'b000100: seq = {0, 1, 8};
      6'b000010: seq = {0, 1, 11};
      default:   legal = 1'b0;
    endcase
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
  task automatic run_instr(input logic [5:0] op, input logic z, input string tag);
    int   seq[$];
    logic legal;
    trace(op, seq, legal);
    opcode = op;
    zero   = z;
    total++;
    if (instr_count !== m_count) begin
      bad++;
      $display("FAIL %s count: got %0d want %0d", tag, instr_count, m_count);
    end
    total++;
    if (illegal_op !== m_illegal) begin
      bad++;
      $display("FAIL %s illegal_op: got %0b want %0b", tag, illegal_op, m_illegal);
    end
    foreach (seq[i]) begin
      total++;
      if (state !== 4'(seq[i])) begin
        bad++;
        $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, state, seq[i]);
      end
      total++;
      if (act !== exp_ctrl(seq[i], z)) begin
        bad++;
        $display("FAIL %s ctrl[%0d] st%0d: got %b want %b", tag, i, seq[i], act,
                 exp_ctrl(seq[i], z));
      end
      @(negedge clk);
    end
    if (legal) m_count = m_count + 16'd1;
    else m_illegal = 1'b1;
  endtask

  task automatic check_tail(input string tag);
    total++;
    if (state !== 4'd0 || instr_count !== m_count || illegal_op !== m_illegal) begin
      bad++;
      $display("FAIL %s end: got st=%0d cnt=%0d ill=%0b want st=0 cnt=%0d ill=%0b", tag,
               state, instr_count, illegal_op, m_count, m_illegal);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b100011; zero = 1'b0;
    m_count = '0; m_illegal = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || instr_count !== 16'd0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset regs: got st=%0d cnt=%0d ill=%0b want 0/0/0", state,
               instr_count, illegal_op);
    end
    total++;
    if (act !== exp_ctrl(0, 1'b0)) begin
      bad++;
      $display("FAIL reset ctrl: got %b want %b", act, exp_ctrl(0, 1'b0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 1'b0, "lw");
    check_tail("lw");
  endtask

  task automatic test_rtype_sw();
    run_instr(6'b000000, 1'b1, "rtype");
    run_instr(6'b101011, 1'b0, "sw");
    check_tail("rtype_sw");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 1'b1, "beq_taken");
    run_instr(6'b000100, 1'b0, "beq_not");
  endtask

  task automatic test_j_addi();
    run_instr(6'b000010, 1'b0, "j");
    run_instr(6'b001000, 1'b1, "addi");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 1'b0, "illegal");
    check_tail("illegal");
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) @(negedge clk);
    total++;
    if (state !== 4'd3) begin
      bad++;
      $display("FAIL midrst pre state: got %0d want 3", state);
    end
    #2 rst_n = 1'b0;
    #1;
    m_count = '0; m_illegal = 1'b0;
    total++;
    if (state !== 4'd0 || instr_count !== 16'd0 || illegal_op !== 1'b0 || pc_en !== 1'b1) begin
      bad++;
      $display("FAIL midrst async: got st=%0d cnt=%0d ill=%0b pc_en=%0b want 0/0/0/1",
               state, instr_count, illegal_op, pc_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (state !== 4'd1) begin
      bad++;
      $display("FAIL midrst release: got st=%0d want 1", state);
    end
    // Finish a harmless illegal fetch to realign on FETCH.
    opcode = 6'b111111;
    @(negedge clk);
    m_illegal = 1'b1;
    check_tail("midrst");
  endtask

  task automatic test_random();
    logic [5:0] pool [7];
    pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 6)];
      run_instr(op, 1'($urandom), "rand");
    end
    check_tail("rand");
  endtask

  task automatic test_wrap();
    force dut.count_q = 16'hffff;
    #1 release dut.count_q;
    m_count = 16'hffff;
    run_instr(6'b000010, 1'b0, "wrap_j");
    total++;
    if (instr_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: got %h want 0000", instr_count);
    end
    run_instr(6'b000100, 1'b0, "wrap_next");
    check_tail("wrap");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sw();
    test_beq();
    test_j_addi();
    test_illegal();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
